// File: rtl/trace_capture_if.sv
// Trace capture port bundle: CPU-side capture inputs plus consumer-side FIFO head and status.
// The master drives pc/inst/cap_en/rd_ready; the slave (trace_capture) drives the rest.
interface trace_capture_if #(
  parameter int unsigned DEPTH = 8
);
  logic [31:0]              pc;
  logic [31:0]              inst;
  logic                     cap_en;
  logic                     rd_ready;
  logic                     rd_valid;
  logic [31:0]              rd_pc;
  logic [31:0]              rd_inst;
  logic [15:0]              rd_seq;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic [15:0]              drop_cnt;

  modport master (
    output pc, inst, cap_en, rd_ready,
    input  rd_valid, rd_pc, rd_inst, rd_seq, full, count, drop_cnt
  );

  modport slave (
    input  pc, inst, cap_en, rd_ready,
    output rd_valid, rd_pc, rd_inst, rd_seq, full, count, drop_cnt
  );
endinterface

// File: rtl/trace_capture.sv
// PC-change trace capture into a show-ahead FIFO with a wrapping sequence number.
// Define TRACE_DROP_CNT_EN to build the saturating dropped-event counter.
module trace_capture #(
  parameter int unsigned DEPTH       = 8,
  parameter logic [31:0] PC_SENTINEL = 32'h44436040
) (
  input logic            clk_in,
  input logic            reset,
  trace_capture_if.slave tc
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [15:0] seq;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   seq_q, seq_d;
  logic [31:0]   pc_prev_q;
  logic          cap_ev, valid, is_full, push, pop;
  entry_t        head;

  always_comb begin
    valid   = (count_q != '0);
    is_full = (count_q == FullCnt);
    cap_ev  = tc.cap_en && (tc.pc != pc_prev_q);
    pop     = valid && tc.rd_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push    = cap_ev && (!is_full || pop);

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    seq_d   = seq_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (cap_ev) seq_d = seq_q + 16'd1;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      seq_q     <= '0;
      pc_prev_q <= PC_SENTINEL;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      seq_q     <= seq_d;
      pc_prev_q <= tc.pc;
    end
  end

  // Storage needs no reset: outputs are masked by rd_valid.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wptr_q] <= '{pc: tc.pc, inst: tc.inst, seq: seq_q};
  end

  assign head        = mem_q[rptr_q];
  assign tc.rd_valid = valid;
  assign tc.rd_pc    = valid ? head.pc   : '0;
  assign tc.rd_inst  = valid ? head.inst : '0;
  assign tc.rd_seq   = valid ? head.seq  : '0;
  assign tc.full     = is_full;
  assign tc.count    = count_q;

`ifdef TRACE_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        drop;

  always_comb begin
    drop       = cap_ev && is_full && !pop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign tc.drop_cnt = drop_cnt_q;
`else
  assign tc.drop_cnt = '0;
`endif
endmodule

// File: tb/tb_trace_capture.sv
// Directed vector bench for trace_capture (DEPTH=8): a stimulus table plus
// hand sequences for overflow, full push/pop, mid-run reset and pointer wrap.
module tb_trace_capture;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] SENT  = 32'h44436040;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trace_capture_if #(.DEPTH(DEPTH)) bus ();

  trace_capture #(.DEPTH(DEPTH), .PC_SENTINEL(SENT)) dut (
    .clk_in (clk),
    .reset  (rst),
    .tc     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_drop;

  typedef struct {
    logic        cap;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rdy;
    logic        val;
    logic [31:0] epc;
    logic [31:0] einst;
    logic [15:0] eseq;
    logic [3:0]  ecnt;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cap, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy);
    bus.cap_en   = cap;
    bus.pc       = pc;
    bus.inst     = inst;
    bus.rd_ready = rdy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
`ifdef TRACE_DROP_CNT_EN
    exp_drop = 2;
`else
    exp_drop = 0;
`endif
    //           cap   pc            inst          rdy   val   epc           einst         seq    cnt
    tbl[0]  = '{1'b1, 32'h00400000, 32'h08100004, 1'b0, 1'b1, 32'h00400000, 32'h08100004, 16'd0, 4'd1};
    tbl[1]  = '{1'b1, 32'h00400000, 32'h08100004, 1'b0, 1'b1, 32'h00400000, 32'h08100004, 16'd0, 4'd1};
    tbl[2]  = '{1'b1, 32'h00400000, 32'h08100004, 1'b0, 1'b1, 32'h00400000, 32'h08100004, 16'd0, 4'd1};
    tbl[3]  = '{1'b1, 32'h00400000, 32'h08100004, 1'b0, 1'b1, 32'h00400000, 32'h08100004, 16'd0, 4'd1};
    tbl[4]  = '{1'b1, 32'h00400000, 32'h08100004, 1'b0, 1'b1, 32'h00400000, 32'h08100004, 16'd0, 4'd1};
    tbl[5]  = '{1'b1, 32'h00400004, 32'h00000011, 1'b1, 1'b1, 32'h00400004, 32'h00000011, 16'd1, 4'd1};
    tbl[6]  = '{1'b0, 32'h00400008, 32'h00000099, 1'b0, 1'b1, 32'h00400004, 32'h00000011, 16'd1, 4'd1};
    tbl[7]  = '{1'b1, 32'h00400008, 32'h00000099, 1'b0, 1'b1, 32'h00400004, 32'h00000011, 16'd1, 4'd1};
    tbl[8]  = '{1'b1, 32'h0040000C, 32'h00000022, 1'b0, 1'b1, 32'h00400004, 32'h00000011, 16'd1, 4'd2};
    tbl[9]  = '{1'b0, 32'h0040000C, 32'h00000022, 1'b1, 1'b1, 32'h0040000C, 32'h00000022, 16'd2, 4'd1};
    tbl[10] = '{1'b0, 32'h0040000C, 32'h00000022, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 16'd0, 4'd0};
    tbl[11] = '{1'b0, 32'h0040000C, 32'h00000022, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 16'd0, 4'd0};
    tbl[12] = '{1'b1, 32'h00400010, 32'h00000033, 1'b0, 1'b1, 32'h00400010, 32'h00000033, 16'd3, 4'd1};

    // Reset state while reset is held
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, bus.rd_valid}, 32'd0);
    chk("rst_pc",    bus.rd_pc,             32'd0);
    chk("rst_inst",  bus.rd_inst,           32'd0);
    chk("rst_seq",   {16'b0, bus.rd_seq},   32'd0);
    chk("rst_full",  {31'b0, bus.full},     32'd0);
    chk("rst_count", {28'b0, bus.count},    32'd0);
    chk("rst_drop",  {16'b0, bus.drop_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table: first capture, held PC, push+pop, cap_en gating, empty pop
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].cap, tbl[i].pc, tbl[i].inst, tbl[i].rdy);
      step();
      chk($sformatf("v%0d_valid", i), {31'b0, bus.rd_valid}, {31'b0, tbl[i].val});
      chk($sformatf("v%0d_pc", i),    bus.rd_pc,             tbl[i].epc);
      chk($sformatf("v%0d_inst", i),  bus.rd_inst,           tbl[i].einst);
      chk($sformatf("v%0d_seq", i),   {16'b0, bus.rd_seq},   {16'b0, tbl[i].eseq});
      chk($sformatf("v%0d_count", i), {28'b0, bus.count},    {28'b0, tbl[i].ecnt});
      chk($sformatf("v%0d_full", i),  {31'b0, bus.full},     32'd0);
    end

    // Overflow: 10 distinct PCs into 8 slots, then full push+pop, then drain
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h1000 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0);
      step();
    end
    chk("ovf_full",  {31'b0, bus.full},     32'd1);
    chk("ovf_count", {28'b0, bus.count},    32'd8);
    chk("ovf_drop",  {16'b0, bus.drop_cnt}, 32'(exp_drop));
    chk("ovf_head",  {16'b0, bus.rd_seq},   32'd0);
    chk("ovf_hpc",   bus.rd_pc,             32'h1000);
    drive(1'b1, 32'h2000, 32'hBB, 1'b1);
    step();
    chk("fpp_count", {28'b0, bus.count},    32'd8);
    chk("fpp_full",  {31'b0, bus.full},     32'd1);
    chk("fpp_drop",  {16'b0, bus.drop_cnt}, 32'(exp_drop));
    drive(1'b0, 32'h2000, 32'hBB, 1'b1);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("drain%0d_seq", j), {16'b0, bus.rd_seq},
          (j < 7) ? 32'(j + 1) : 32'd10);
      chk($sformatf("drain%0d_pc", j), bus.rd_pc,
          (j < 7) ? 32'h1000 + 32'(4 * (j + 1)) : 32'h2000);
      step();
    end
    chk("drain_valid", {31'b0, bus.rd_valid}, 32'd0);
    chk("drain_count", {28'b0, bus.count},    32'd0);

    // Mid-cycle reset with 3 entries held
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3000 + 32'(4 * i), 32'h50 + 32'(i), 1'b0);
      step();
    end
    chk("pre_rst_count", {28'b0, bus.count}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_valid", {31'b0, bus.rd_valid}, 32'd0);
    chk("mrst_count", {28'b0, bus.count},    32'd0);
    chk("mrst_pc",    bus.rd_pc,             32'd0);
    drive(1'b1, SENT, 32'h66, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst%0d_count", i), {28'b0, bus.count}, 32'd0);
    end
    drive(1'b1, 32'h3100, 32'h77, 1'b0);
    step();
    chk("post_rst_valid", {31'b0, bus.rd_valid}, 32'd1);
    chk("post_rst_pc",    bus.rd_pc,             32'h3100);
    chk("post_rst_seq",   {16'b0, bus.rd_seq},   32'd0);

    // 20 push/pop pairs across the pointer wrap
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 32'h5000 + 32'(4 * k), 32'(k), 1'b1);
      if (k > 0) chk($sformatf("wrap%0d_seq", k), {16'b0, bus.rd_seq}, 32'(k - 1));
      step();
      chk($sformatf("wrap%0d_count", k), {28'b0, bus.count}, 32'd1);
    end
    chk("wrap_last_seq",  {16'b0, bus.rd_seq}, 32'd19);
    chk("wrap_last_inst", bus.rd_inst,         32'd19);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 SHALL provide parameter DEPTH, default 8, FIFO entry count (power of two, 2..64).
REQ-002 SHALL provide parameter PC_SENTINEL, default 32'h44436040, reset value of the previous-PC register.
REQ-003 SHALL have port clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port pc  input  32  current PC from the sccomp_dataflow CPU.
REQ-006 SHALL have port inst  input  32  instruction word paired with pc.
REQ-007 SHALL have port cap_en  input  1  capture enable.
REQ-008 SHALL have port rd_ready  input  1  consumer accepts the head entry.
REQ-009 SHALL have port rd_valid  output  1  head entry present.
REQ-010 SHALL have port rd_pc  output  32  head entry PC.
REQ-011 SHALL have port rd_inst  output  32  head entry instruction.
REQ-012 SHALL have port rd_seq  output  16  head entry sequence number.
REQ-013 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 SHALL have port drop_cnt  output  16  dropped-event count (see Configuration).

Function
REQ-016 SHALL keep register pc_prev, loaded with pc every clock edge regardless of cap_en.
REQ-017 SHALL raise a capture event in a cycle when cap_en=1 and pc != pc_prev.
REQ-018 SHALL keep a 16-bit sequence counter seq that increments, wrapping FFFF->0000, on every capture event, including dropped events.
REQ-019 SHALL push {pc, inst, seq} on a capture event when not full, or when full with a pop in the same cycle.
REQ-020 SHALL drop a capture event when full and no pop occurs in that cycle.
REQ-021 SHALL pop the head entry on a clock edge where rd_valid=1 and rd_ready=1.
REQ-022 SHALL drive rd_valid=1 exactly when count != 0.
REQ-023 SHALL drive rd_pc, rd_inst and rd_seq from the head entry (show-ahead) when rd_valid=1, and 0 when rd_valid=0.
REQ-024 SHALL make a pushed entry visible at the head one cycle after its capture edge when the FIFO was empty (latency 1).
REQ-025 SHALL leave count unchanged when a push and a pop occur in the same cycle.
REQ-026 SHALL ignore rd_ready when the FIFO is empty, with no underflow and no pointer movement.
REQ-027 SHALL wrap the read and write pointers modulo DEPTH, preserving entry order across the wrap.
REQ-028 SHALL drive full=1 exactly when count == DEPTH.

Reset
REQ-029 SHALL asynchronously clear pointers, count, seq and drop_cnt to 0, and set pc_prev to PC_SENTINEL, while reset=1.
REQ-030 SHALL drive rd_valid=0, rd_pc=0, rd_inst=0, rd_seq=0, full=0, count=0 and drop_cnt=0 during reset.
REQ-031 SHALL discard all held entries on reset mid-operation, with no partial entry surviving.
REQ-032 SHALL take the first capture event after reset deassertion whenever pc differs from PC_SENTINEL.

Configuration
REQ-033 SHALL, with macro TRACE_DROP_CNT_EN defined, increment drop_cnt by 1 per dropped event, saturating at 16'hFFFF.
REQ-034 SHALL, with TRACE_DROP_CNT_EN undefined, tie drop_cnt to 0 and compile out the drop-counter logic.

Verification
REQ-035 SHALL cover: reset release, cap_en=1, pc=32'h00400000, inst=32'h08100004 -> next cycle rd_valid=1, rd_pc=00400000, rd_inst=08100004, rd_seq=0.
REQ-036 SHALL cover: pc held constant for 5 cycles with cap_en=1 -> exactly one entry, count=1.
REQ-037 SHALL cover: 10 distinct PCs, rd_ready=0, DEPTH=8 -> full=1, count=8, drop_cnt=2 (macro defined) or 0 (undefined), then 8 pops return seq 0..7 in order.
REQ-038 SHALL cover: full FIFO, a new PC and rd_ready=1 in the same cycle -> entry accepted, count stays 8, drop_cnt unchanged.
REQ-039 SHALL cover: 3 entries held, reset asserted mid-cycle -> rd_valid=0 and count=0 immediately, with no entries after release until a new PC change.
REQ-040 SHALL cover: 20 push/pop pairs with rd_ready=1 -> pointers wrap, rd_seq increases monotonically 0..19, and count never exceeds 1.
